// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD down-timer: FSM state encoding and
// decade limits, plus the load-time digit clamp.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Non-BCD preset codes (A..F) saturate to the largest decimal digit.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// Control/data bundle of the BCD down-timer; the timer is the slave side.
interface bcd_down_timer_if #(
    parameter int DIGITS = 4
);
    logic                  tick_in;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  stop;
    logic [4*DIGITS-1:0]   cnt;
    logic                  busy;
    logic                  done;

    modport master (
        output tick_in, load, load_val, start, stop,
        input  cnt, busy, done
    );

    modport slave (
        input  tick_in, load, load_val, start, stop,
        output cnt, busy, done
    );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD decade of the down-counter: clamped preset load and borrow-driven
// decrement with 0 -> 9 wrap, borrowing from the next decade.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       borrow_in,
    input  logic       load,
    input  logic [3:0] load_digit,
    output logic [3:0] digit,
    output logic       borrow_out
);

    assign borrow_out = borrow_in && (digit == BCD_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            digit <= BCD_ZERO;
        else if (load)
            digit <= bcd_clamp(load_digit);
        else if (borrow_in)
            digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Cascaded BCD down-timer: IDLE/RUN/DONE control with a one-cycle done pulse
// when the count reaches zero; the decades themselves live in bcd_down_digit.
module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input logic              clk,
    input logic              rst_n,
    bcd_down_timer_if.slave  bus
);

    state_t              state, state_nxt;
    logic                done_nxt;
    logic [DIGITS-1:0][3:0] digits;
    logic [DIGITS:0]     borrow;
    logic                cnt_zero, cnt_one;
    logic                unused_borrow;

    assign cnt_zero = (bus.cnt == '0);
    assign cnt_one  = (bus.cnt == (4*DIGITS)'(1));

    // RUN is only ever entered with a non-zero count and left on the tick that
    // reaches zero, so the borrow chain can never wrap the count below zero.
    assign borrow[0] = (state == RUN) && bus.tick_in && !bus.load && !bus.stop;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            bcd_down_digit u_digit (
                .clk        (clk),
                .rst_n      (rst_n),
                .borrow_in  (borrow[i]),
                .load       (bus.load),
                .load_digit (bus.load_val[4*i +: 4]),
                .digit      (digits[i]),
                .borrow_out (borrow[i+1])
            );
        end
    endgenerate

    assign bus.cnt       = digits;
    assign unused_borrow = borrow[DIGITS];

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (bus.load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.stop && bus.start) begin
                        if (cnt_zero) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_nxt = IDLE;
                    end else if (bus.tick_in && cnt_one) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus.done <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            bus.done <= done_nxt;
            bus.busy <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: countdown, borrow ripple, clamp, priority,
// start-at-zero, pause and asynchronous reset.
module tb_bcd_down_timer;

    localparam int DIGITS = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   fails;

    bcd_down_timer_if #(.DIGITS(DIGITS)) bus ();

    bcd_down_timer #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.tick_in = 1'b0;
    endtask

    initial begin
        total = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.load_val = '0;
        clr();

        // reset state
        #3;
        chk("rst_cnt",  bus.cnt, 16'h0000);
        chk("rst_busy", 16'(bus.busy), 16'h0);
        chk("rst_done", 16'(bus.done), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // basic countdown 3 -> 0
        bus.load = 1'b1; bus.load_val = 16'h0003;
        step(); clr();
        chk("cd_load", bus.cnt, 16'h0003);
        chk("cd_load_busy", 16'(bus.busy), 16'h0);
        bus.start = 1'b1;
        step(); clr();
        chk("cd_start_busy", 16'(bus.busy), 16'h1);
        chk("cd_start_cnt", bus.cnt, 16'h0003);
        bus.tick_in = 1'b1;
        step();
        chk("cd_t1", bus.cnt, 16'h0002);
        chk("cd_t1_done", 16'(bus.done), 16'h0);
        step();
        chk("cd_t2", bus.cnt, 16'h0001);
        step(); clr();
        chk("cd_t3", bus.cnt, 16'h0000);
        chk("cd_t3_done", 16'(bus.done), 16'h1);
        chk("cd_t3_busy", 16'(bus.busy), 16'h0);
        step();
        chk("cd_done_once", 16'(bus.done), 16'h0);
        // DONE ignores start/tick/stop
        bus.start = 1'b1; bus.tick_in = 1'b1; bus.stop = 1'b1;
        step(); clr();
        chk("done_hold_cnt",  bus.cnt, 16'h0000);
        chk("done_hold_done", 16'(bus.done), 16'h0);
        chk("done_hold_busy", 16'(bus.busy), 16'h0);

        // borrow ripple 1000 -> 0999
        bus.load = 1'b1; bus.load_val = 16'h1000;
        step(); clr();
        bus.start = 1'b1;
        step(); clr();
        bus.tick_in = 1'b1;
        step(); clr();
        chk("ripple_cnt",  bus.cnt, 16'h0999);
        chk("ripple_busy", 16'(bus.busy), 16'h1);

        // priority: load beats stop and tick while running
        bus.load = 1'b1; bus.stop = 1'b1; bus.tick_in = 1'b1; bus.load_val = 16'h0042;
        step(); clr();
        chk("prio_cnt",  bus.cnt, 16'h0042);
        chk("prio_busy", 16'(bus.busy), 16'h0);
        chk("prio_done", 16'(bus.done), 16'h0);
        bus.tick_in = 1'b1;
        step(); clr();
        chk("idle_tick", bus.cnt, 16'h0042);

        // clamp of non-BCD preset digits
        bus.load = 1'b1; bus.load_val = 16'hA0F5;
        step(); clr();
        chk("clamp_cnt",  bus.cnt, 16'h9095);
        chk("clamp_busy", 16'(bus.busy), 16'h0);

        // start with zero count goes straight to DONE
        bus.load = 1'b1; bus.load_val = 16'h0000;
        step(); clr();
        bus.start = 1'b1;
        step(); clr();
        chk("zstart_done", 16'(bus.done), 16'h1);
        chk("zstart_busy", 16'(bus.busy), 16'h0);
        step();
        chk("zstart_done_once", 16'(bus.done), 16'h0);

        // pause: stop beats tick
        bus.load = 1'b1; bus.load_val = 16'h0005;
        step(); clr();
        bus.start = 1'b1;
        step(); clr();
        chk("pause_run_busy", 16'(bus.busy), 16'h1);
        bus.stop = 1'b1; bus.tick_in = 1'b1;
        step(); clr();
        chk("pause_cnt",  bus.cnt, 16'h0005);
        chk("pause_busy", 16'(bus.busy), 16'h0);
        chk("pause_done", 16'(bus.done), 16'h0);

        // resume and decrement across a decade edge, back-to-back ticks
        bus.load = 1'b1; bus.load_val = 16'h0101;
        step(); clr();
        bus.start = 1'b1;
        step(); clr();
        bus.tick_in = 1'b1;
        step();
        chk("b2b_1", bus.cnt, 16'h0100);
        step(); clr();
        chk("b2b_2", bus.cnt, 16'h0099);

        // asynchronous reset mid-RUN
        bus.load = 1'b1; bus.load_val = 16'h0123;
        step(); clr();
        bus.start = 1'b1;
        step(); clr();
        chk("ar_pre_busy", 16'(bus.busy), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cnt",  bus.cnt, 16'h0000);
        chk("ar_busy", 16'(bus.busy), 16'h0);
        #1 rst_n = 1'b1;
        step();
        chk("ar_post_done", 16'(bus.done), 16'h0);
        step();
        chk("ar_post_done2", 16'(bus.done), 16'h0);
        chk("ar_post_cnt",   bus.cnt, 16'h0000);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of cascaded BCD decades, range 1..8.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port tick_in, input, 1 bit: count-enable pulse, one decrement per high cycle (same pulse format as the up-counter carry output).
REQ-005 SHALL have port load, input, 1 bit: loads load_val into the count.
REQ-006 SHALL have port load_val, input, 4*DIGITS bits: BCD preset, digit 0 in bits [3:0].
REQ-007 SHALL have port start, input, 1 bit: arms counting.
REQ-008 SHALL have port stop, input, 1 bit: pauses counting and holds the count.
REQ-009 SHALL have port cnt, output, 4*DIGITS bits: registered BCD count value.
REQ-010 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 SHALL have port done, output, 1 bit: one-cycle registered pulse on reaching zero.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 Input priority each cycle SHALL be load > stop > start > tick_in.
REQ-014 On load, in any state: cnt <= load_val next edge; state -> IDLE; done = 0; tick_in that cycle ignored.
REQ-015 Any load_val digit > 9 SHALL be clamped to 9 on load; all other digits load unchanged.
REQ-016 In IDLE, start with cnt != 0 -> RUN. In IDLE, start with cnt == 0 -> DONE, with done = 1 for the following cycle.
REQ-017 In RUN, stop -> IDLE; cnt held; no done pulse.
REQ-018 In RUN, tick_in = 1 SHALL decrement cnt by one in BCD, visible the cycle after tick_in is sampled.
REQ-019 Decrement SHALL ripple a borrow: digit 0 -> 9 and borrow into the next digit; a digit without a borrow in is unchanged.
REQ-020 In RUN, a tick with cnt == 1 (all upper digits 0) SHALL produce, on the same edge, cnt = 0, state -> DONE and done = 1.
REQ-021 done SHALL be high for exactly one cycle per entry to DONE; otherwise 0.
REQ-022 In DONE, cnt SHALL hold at 0, and tick_in, start and stop are ignored; only load leaves DONE.
REQ-023 In IDLE and DONE, tick_in SHALL NOT alter cnt.
REQ-024 cnt SHALL never leave the all-digits-in-range 0..9 domain and never wrap below 0.
REQ-025 Multiple tick_in cycles back-to-back SHALL each decrement once; there is no minimum spacing.
REQ-026 busy SHALL be registered and equal (state == RUN).

Reset
REQ-027 While rst_n = 0: state = IDLE, cnt = 0, done = 0, busy = 0, applied asynchronously.
REQ-028 Deassertion of rst_n SHALL take effect at the next rising clk edge; reset mid-RUN discards the count with no done pulse.

Structure
REQ-029 A shared package bcd_pkg SHALL hold the state enum (IDLE, RUN, DONE), BCD_MAX = 4'd9 and BCD_ZERO = 4'd0.
REQ-030 A sub-module bcd_down_digit (one decade) SHALL be used, instantiated DIGITS times.
REQ-031 bcd_down_digit SHALL have inputs borrow_in, load, load_digit, and outputs digit and borrow_out.
REQ-032 In bcd_down_digit, borrow_out SHALL be combinational: borrow_in and digit == 0.
REQ-033 The top level SHALL hold the FSM and the done/busy registers; borrow_in of digit 0 = (state == RUN) and tick_in and not load and not stop.

Verification
REQ-034 Scenario, basic countdown: load 0x0003, start, three tick_in pulses -> cnt 0x0002, 0x0001, 0x0000; done high one cycle exactly with cnt = 0x0000; state DONE.
REQ-035 Scenario, borrow ripple: load 0x1000, start, one tick_in -> cnt = 0x0999 next cycle; busy remains 1.
REQ-036 Scenario, clamp: load_val 0xA0F5 -> cnt = 0x9095 after load; state IDLE.
REQ-037 Scenario, priority: in RUN, load = stop = tick_in = 1 with load_val 0x0042 -> cnt = 0x0042, state IDLE, no decrement, done = 0.
REQ-038 Scenario, start at zero and pause: start with cnt = 0 -> done pulse, DONE. Separately, RUN at 0x0005, stop with tick_in = 1 -> cnt stays 0x0005, busy = 0.
REQ-039 Scenario, async reset: rst_n pulled low mid-cycle in RUN at cnt 0x0123 -> cnt = 0, busy = 0 immediately without a clock edge; no done pulse after release.
